ls_queue: RTL and testbench
===========================

LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, queue entries; power of two, 4..64.
REQ-002 SHALL provide parameter DATA_W, default 32, operand/address/data width.
REQ-003 SHALL provide parameter ROB_W, default 4, ROB id width; id 0 means "no dependency".
REQ-004 SHALL provide parameter OP_W, default 6, opcode width; opcodes <= LOAD_MAX are loads, others stores.
REQ-005 SHALL provide parameter LOAD_MAX, default 5, highest load opcode.
REQ-006 SHALL provide parameter FULL_MARGIN, default 3, free-entry margin for full.
REQ-007 SHALL provide parameter IO_ADDR, default 32'h30000, memory-mapped IO address.
REQ-008 SHALL provide ports, in order:
 - clk  in  1  clock
 - rst  in  1  reset; one clock; reset is synchronous and active-high
 - rdy  in  1  global stall; low freezes all state
 - enq_valid  in  1  dispatcher enqueue
 - enq_op  in  OP_W  opcode
 - enq_q1, enq_q2  in  ROB_W  base/store-data dependency tags
 - enq_v1, enq_v2  in  DATA_W  base/store-data values
 - enq_imm  in  DATA_W  offset
 - enq_rob_id  in  ROB_W  owning ROB entry
 - cdb0_valid, cdb1_valid  in  1  ALU/LSU result broadcast
 - cdb0_rob_id, cdb1_rob_id  in  ROB_W  broadcast tag
 - cdb0_data, cdb1_data  in  DATA_W  broadcast value
 - lsu_busy  in  1  LSU cannot accept
 - issue_valid  out  1  one-cycle request to LSU
 - issue_op  out  OP_W; issue_addr  out  DATA_W; issue_data  out  DATA_W
 - commit_valid  in  1; commit_rob_id  in  ROB_W  ROB commit
 - io_ok_rob_id  in  ROB_W  ROB id permitted to perform IO load
 - io_req_rob_id  out  ROB_W  head id if head address == IO_ADDR, else 0
 - flush  in  1  misprediction
 - full  out  1  count >= DEPTH-FULL_MARGIN
 - count  out  clog2(DEPTH)+1  occupied entries
 - overflow_err  out  1  sticky: enqueue attempted with count == DEPTH

Function
REQ-009 SHALL be circular queue, head/tail pointers wrap DEPTH-1 -> 0; valid entries [head, tail).
REQ-010 Enqueue SHALL write entry at tail, set busy, clear committed, advance tail; ignored (overflow_err set) if count == DEPTH.
REQ-011 Enqueue SHALL capture same-cycle CDB: tag match on cdb0 or cdb1 stores that channel's data, tag 0; cdb0 wins if both match; tag 0 never matches.
REQ-012 Each cycle SHALL wake every busy entry whose q1/q2 equals a valid CDB tag, loading data and clearing tag; cdb0 priority.
REQ-013 Head address SHALL be v1+imm, DATA_W bits, wrap-around modulo 2^DATA_W.
REQ-014 Head SHALL issue when busy, q1==0, q2==0, !lsu_busy, and either (store and committed) or (load and (addr != IO_ADDR or io_ok_rob_id == entry rob_id)).
REQ-015 Issue SHALL, next cycle, drive issue_valid=1 for exactly one cycle with op, addr, data (v2 for store, 0 for load); clear entry; advance head.
REQ-016 commit_valid SHALL set committed on the busy entry with matching rob_id; stores only wait on it, loads ignore it.
REQ-017 Count SHALL update by +enq -issue; simultaneous enqueue and issue leave count unchanged.
REQ-018 flush SHALL discard all uncommitted entries and keep committed stores: tail <= head + committed_count, count <= committed_count; same-cycle enqueue dropped; same-cycle issue of a committed head still proceeds.
REQ-019 Committed stores SHALL be contiguous from head; flush keeps them in order.
REQ-020 rdy low SHALL hold all registers; issue_valid holds its value.

Reset
REQ-021 rst SHALL clear head, tail, count, all busy/committed bits, tags to 0, issue_valid, issue_op, issue_addr, issue_data, overflow_err to 0; rst dominates flush and rdy.
REQ-022 Reset mid-issue SHALL drop the pending request; issue_valid 0 next cycle.

Verification
REQ-023 Load enq v1=0x100, imm=4, tags 0, lsu_busy=0 -> issue_valid one cycle later, addr=0x104, data=0, count back to 0.
REQ-024 Store enq q2=3; cdb1 tag 3 data 0xAB; commit rob 7 -> issue after commit only, data=0xAB.
REQ-025 Load addr 0x30000, rob 5, io_ok_rob_id=0 -> io_req_rob_id=5, no issue; io_ok_rob_id=5 -> issue.
REQ-026 DEPTH=16: enqueue 16 entries across wrap (head=10) -> full from count 13, 17th enqueue sets overflow_err, count stays 16.
REQ-027 Two committed stores plus three uncommitted entries, assert flush -> count=2, both stores later issue in order.

Source files
------------

// File: rtl/ls_queue.sv
// rtl/ls_queue.sv - in-order load/store queue with CDB wake-up, commit tracking and flush recovery
// Entries issue strictly from the head; committed stores form a contiguous prefix that survives flush.
module ls_queue #(
  parameter int                DEPTH       = 16,
  parameter int                DATA_W      = 32,
  parameter int                ROB_W       = 4,
  parameter int                OP_W        = 6,
  parameter int                LOAD_MAX    = 5,
  parameter int                FULL_MARGIN = 3,
  parameter logic [DATA_W-1:0] IO_ADDR     = 'h30000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     enq_valid,
  input  logic [OP_W-1:0]          enq_op,
  input  logic [ROB_W-1:0]         enq_q1,
  input  logic [ROB_W-1:0]         enq_q2,
  input  logic [DATA_W-1:0]        enq_v1,
  input  logic [DATA_W-1:0]        enq_v2,
  input  logic [DATA_W-1:0]        enq_imm,
  input  logic [ROB_W-1:0]         enq_rob_id,
  input  logic                     cdb0_valid,
  input  logic [ROB_W-1:0]         cdb0_rob_id,
  input  logic [DATA_W-1:0]        cdb0_data,
  input  logic                     cdb1_valid,
  input  logic [ROB_W-1:0]         cdb1_rob_id,
  input  logic [DATA_W-1:0]        cdb1_data,
  input  logic                     lsu_busy,
  output logic                     issue_valid,
  output logic [OP_W-1:0]          issue_op,
  output logic [DATA_W-1:0]        issue_addr,
  output logic [DATA_W-1:0]        issue_data,
  input  logic                     commit_valid,
  input  logic [ROB_W-1:0]         commit_rob_id,
  input  logic [ROB_W-1:0]         io_ok_rob_id,
  output logic [ROB_W-1:0]         io_req_rob_id,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH - FULL_MARGIN);
  localparam logic [OP_W-1:0] LMAX    = OP_W'(LOAD_MAX);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  committed;
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [ROB_W-1:0]  q1_q  [DEPTH];
  logic [ROB_W-1:0]  q2_q  [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [DATA_W-1:0] v1_q  [DEPTH];
  logic [DATA_W-1:0] v2_q  [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic [DATA_W-1:0] head_addr;
  logic              head_load;
  logic              head_ready;
  logic              head_go;
  logic              issue_fire;
  logic              at_cap;
  logic              enq_fire;
  logic [CW-1:0]     committed_count;
  logic [ROB_W-1:0]  enq_q1_n;
  logic [ROB_W-1:0]  enq_q2_n;
  logic [DATA_W-1:0] enq_v1_n;
  logic [DATA_W-1:0] enq_v2_n;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op <= LMAX;
  endfunction

  // Tag 0 means "operand ready", so it must never be woken by a broadcast.
  function automatic logic tag_hit(input logic valid, input logic [ROB_W-1:0] tag,
                                   input logic [ROB_W-1:0] q);
    return valid && (q != '0) && (tag == q);
  endfunction

  always_comb begin
    head_addr  = v1_q[head] + imm_q[head];
    head_load  = is_load(op_q[head]);
    head_ready = busy[head] && (q1_q[head] == '0) && (q2_q[head] == '0);
    head_go    = head_ready && !lsu_busy &&
                 (head_load ? ((head_addr != IO_ADDR) || (io_ok_rob_id == rob_q[head]))
                            : committed[head]);
    // Flush cancels everything uncommitted, including a head load about to go.
    issue_fire = head_go && (!flush || committed[head]);
    at_cap     = (count == DEPTH_C);
    enq_fire   = enq_valid && !flush && !at_cap;

    committed_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy[i] && committed[i]) committed_count = committed_count + CNT_ONE;
    end
  end

  always_comb begin
    enq_q1_n = enq_q1;
    enq_v1_n = enq_v1;
    enq_q2_n = enq_q2;
    enq_v2_n = enq_v2;
    if (tag_hit(cdb0_valid, cdb0_rob_id, enq_q1)) begin
      enq_q1_n = '0;
      enq_v1_n = cdb0_data;
    end else if (tag_hit(cdb1_valid, cdb1_rob_id, enq_q1)) begin
      enq_q1_n = '0;
      enq_v1_n = cdb1_data;
    end
    if (tag_hit(cdb0_valid, cdb0_rob_id, enq_q2)) begin
      enq_q2_n = '0;
      enq_v2_n = cdb0_data;
    end else if (tag_hit(cdb1_valid, cdb1_rob_id, enq_q2)) begin
      enq_q2_n = '0;
      enq_v2_n = cdb1_data;
    end
  end

  assign full          = (count >= FULL_C);
  assign io_req_rob_id = (busy[head] && (head_addr == IO_ADDR)) ? rob_q[head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      committed    <= '0;
      issue_valid  <= 1'b0;
      issue_op     <= '0;
      issue_addr   <= '0;
      issue_data   <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q1_q[i] <= '0;
        q2_q[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          if (tag_hit(cdb0_valid, cdb0_rob_id, q1_q[i])) begin
            q1_q[i] <= '0;
            v1_q[i] <= cdb0_data;
          end else if (tag_hit(cdb1_valid, cdb1_rob_id, q1_q[i])) begin
            q1_q[i] <= '0;
            v1_q[i] <= cdb1_data;
          end
          if (tag_hit(cdb0_valid, cdb0_rob_id, q2_q[i])) begin
            q2_q[i] <= '0;
            v2_q[i] <= cdb0_data;
          end else if (tag_hit(cdb1_valid, cdb1_rob_id, q2_q[i])) begin
            q2_q[i] <= '0;
            v2_q[i] <= cdb1_data;
          end
          if (commit_valid && !flush && (rob_q[i] == commit_rob_id) && !is_load(op_q[i]))
            committed[i] <= 1'b1;
          if (flush && !committed[i])
            busy[i] <= 1'b0;
        end
      end

      issue_valid <= issue_fire;
      if (issue_fire) begin
        issue_op        <= op_q[head];
        issue_addr      <= head_addr;
        issue_data      <= head_load ? '0 : v2_q[head];
        busy[head]      <= 1'b0;
        committed[head] <= 1'b0;
        head            <= head + PTR_ONE;
      end

      if (enq_fire) begin
        busy[tail]      <= 1'b1;
        committed[tail] <= 1'b0;
        op_q[tail]      <= enq_op;
        q1_q[tail]      <= enq_q1_n;
        q2_q[tail]      <= enq_q2_n;
        v1_q[tail]      <= enq_v1_n;
        v2_q[tail]      <= enq_v2_n;
        imm_q[tail]     <= enq_imm;
        rob_q[tail]     <= enq_rob_id;
        tail            <= tail + PTR_ONE;
      end

      if (enq_valid && !flush && at_cap)
        overflow_err <= 1'b1;

      // Committed stores are a prefix from the old head, so the surviving tail is head+N.
      if (flush) begin
        tail  <= head + committed_count[PW-1:0];
        count <= committed_count - (issue_fire ? CNT_ONE : '0);
      end else begin
        count <= count + (enq_fire ? CNT_ONE : '0) - (issue_fire ? CNT_ONE : '0);
      end
    end
  end

endmodule

// File: tb/tb_ls_queue.sv
// tb/tb_ls_queue.sv - randomized and directed checks of ls_queue against a queue-based reference model
module tb_ls_queue;

  logic        clk;
  logic        rst, rdy, enq_valid;
  logic [5:0]  enq_op;
  logic [3:0]  enq_q1, enq_q2, enq_rob_id;
  logic [31:0] enq_v1, enq_v2, enq_imm;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_rob_id, cdb1_rob_id;
  logic [31:0] cdb0_data, cdb1_data;
  logic        lsu_busy;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_addr, issue_data;
  logic        commit_valid;
  logic [3:0]  commit_rob_id, io_ok_rob_id, io_req_rob_id;
  logic        flush, full, overflow_err;
  logic [4:0]  count;

  ls_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enq_valid(enq_valid), .enq_op(enq_op), .enq_q1(enq_q1), .enq_q2(enq_q2),
    .enq_v1(enq_v1), .enq_v2(enq_v2), .enq_imm(enq_imm), .enq_rob_id(enq_rob_id),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_data(cdb1_data),
    .lsu_busy(lsu_busy), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_addr(issue_addr), .issue_data(issue_data),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .io_ok_rob_id(io_ok_rob_id), .io_req_rob_id(io_req_rob_id),
    .flush(flush), .full(full), .count(count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  q1, q2, rob;
    logic [31:0] v1, v2, imm;
    bit          committed;
  } ent_t;

  localparam logic [31:0] IO = 32'h30000;

  ent_t        mq[$];
  bit          m_iv, m_ovf;
  logic [5:0]  m_op;
  logic [31:0] m_addr, m_data;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void resolve(inout logic [3:0] q, inout logic [31:0] v);
    if (q != 0 && cdb0_valid && cdb0_rob_id == q) begin
      v = cdb0_data; q = 0;
    end else if (q != 0 && cdb1_valid && cdb1_rob_id == q) begin
      v = cdb1_data; q = 0;
    end
  endfunction

  task automatic model_step();
    ent_t        e, n;
    ent_t        kept[$];
    bit          fire, ld, accept;
    logic [31:0] a;
    if (rst) begin
      mq.delete();
      m_iv = 0; m_op = 0; m_addr = 0; m_data = 0; m_ovf = 0;
      return;
    end
    if (!rdy) return;
    fire = 0; ld = 0; a = 0;
    if (mq.size() > 0) begin
      e = mq[0];
      ld = (e.op <= 5);
      a = e.v1 + e.imm;
      fire = e.q1 == 0 && e.q2 == 0 && !lsu_busy &&
             (ld ? (a != IO || io_ok_rob_id == e.rob) : e.committed) &&
             (!flush || e.committed);
    end
    m_iv = fire;
    if (fire) begin
      m_op = e.op; m_addr = a; m_data = ld ? 32'h0 : e.v2;
    end
    accept = enq_valid && !flush && mq.size() < 16;
    if (enq_valid && !flush && mq.size() == 16) m_ovf = 1;
    foreach (mq[i]) begin
      n = mq[i];
      resolve(n.q1, n.v1);
      resolve(n.q2, n.v2);
      if (commit_valid && !flush && n.op > 5 && n.rob == commit_rob_id) n.committed = 1;
      if (!flush || mq[i].committed) kept.push_back(n);
    end
    mq = kept;
    if (fire) void'(mq.pop_front());
    if (accept) begin
      n.op = enq_op; n.q1 = enq_q1; n.q2 = enq_q2; n.v1 = enq_v1; n.v2 = enq_v2;
      n.imm = enq_imm; n.rob = enq_rob_id; n.committed = 0;
      resolve(n.q1, n.v1);
      resolve(n.q2, n.v2);
      mq.push_back(n);
    end
  endtask

  task automatic compare_all();
    logic [3:0]  exp_io;
    logic [31:0] a;
    exp_io = 0;
    if (mq.size() > 0) begin
      a = mq[0].v1 + mq[0].imm;
      if (a == IO) exp_io = mq[0].rob;
    end
    check("count", count, mq.size());
    check("full", full, mq.size() >= 13);
    check("overflow_err", overflow_err, m_ovf);
    check("io_req_rob_id", io_req_rob_id, exp_io);
    check("issue_valid", issue_valid, m_iv);
    if (m_iv) begin
      check("issue_op", issue_op, m_op);
      check("issue_addr", issue_addr, m_addr);
      check("issue_data", issue_data, m_data);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; rdy = 1; enq_valid = 0; enq_op = 0; enq_q1 = 0; enq_q2 = 0;
    enq_v1 = 0; enq_v2 = 0; enq_imm = 0; enq_rob_id = 0;
    cdb0_valid = 0; cdb0_rob_id = 0; cdb0_data = 0;
    cdb1_valid = 0; cdb1_rob_id = 0; cdb1_data = 0;
    lsu_busy = 0; commit_valid = 0; commit_rob_id = 0; io_ok_rob_id = 0; flush = 0;
  endtask

  task automatic set_enq(input logic [5:0] op, input logic [3:0] q1, input logic [3:0] q2,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [3:0] rob);
    idle();
    enq_valid = 1; enq_op = op; enq_q1 = q1; enq_q2 = q2;
    enq_v1 = v1; enq_v2 = v2; enq_imm = imm; enq_rob_id = rob;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    idle();
  endtask

  task automatic gen_random();
    logic [3:0] id;
    bit         ok, used;
    int         k;
    idle();
    rst      = ($urandom_range(0, 199) == 0);
    rdy      = ($urandom_range(0, 9) != 0);
    lsu_busy = ($urandom_range(0, 3) == 0);
    flush    = ($urandom_range(0, 39) == 0);
    ok = 0;
    id = 0;
    for (int t = 0; t < 16 && !ok; t++) begin
      id = 4'($urandom_range(1, 15));
      used = 0;
      foreach (mq[i]) if (mq[i].rob == id) used = 1;
      ok = !used;
    end
    if (ok && $urandom_range(0, 1) == 1) begin
      enq_valid  = 1;
      enq_op     = 6'($urandom_range(0, 11));
      enq_q1     = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
      enq_q2     = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
      enq_imm    = $urandom;
      enq_v1     = ($urandom_range(0, 7) == 0) ? IO - enq_imm : $urandom;
      enq_v2     = $urandom;
      enq_rob_id = id;
    end
    cdb0_valid  = ($urandom_range(0, 1) == 1);
    cdb0_rob_id = 4'($urandom_range(0, 15));
    cdb0_data   = $urandom;
    cdb1_valid  = ($urandom_range(0, 1) == 1);
    cdb1_rob_id = ($urandom_range(0, 3) == 0) ? cdb0_rob_id : 4'($urandom_range(0, 15));
    cdb1_data   = $urandom;
    k = 0;
    while (k < mq.size() && mq[k].committed) k++;
    if (k < mq.size() && mq[k].op > 5 && $urandom_range(0, 1) == 1) begin
      commit_valid  = 1;
      commit_rob_id = mq[k].rob;
    end
    if (mq.size() > 0 && $urandom_range(0, 1) == 1) io_ok_rob_id = mq[0].rob;
    else io_ok_rob_id = 4'($urandom_range(0, 15));
  endtask

  initial begin
    idle();
    do_reset();
    check("rst_count", count, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_overflow", overflow_err, 0);

    // Plain load issues one cycle after it lands.
    set_enq(6'd0, 4'd0, 4'd0, 32'h100, 32'h0, 32'h4, 4'd1);
    cycle();
    idle();
    cycle();
    check("t23_valid", issue_valid, 1);
    check("t23_addr", issue_addr, 32'h104);
    check("t23_data", issue_data, 0);
    check("t23_count", count, 0);
    cycle();
    check("t23_pulse", issue_valid, 0);

    // Store waits on cdb1 data and then on commit.
    set_enq(6'd8, 4'd0, 4'd3, 32'h200, 32'h55, 32'h0, 4'd7);
    cycle();
    idle();
    cdb1_valid = 1; cdb1_rob_id = 4'd3; cdb1_data = 32'hAB;
    cycle();
    idle();
    repeat (3) begin
      cycle();
      check("t24_wait", issue_valid, 0);
    end
    commit_valid = 1; commit_rob_id = 4'd7;
    cycle();
    check("t24_wait_commit", issue_valid, 0);
    idle();
    cycle();
    check("t24_valid", issue_valid, 1);
    check("t24_data", issue_data, 32'hAB);

    // IO load blocks until the ROB grants it.
    set_enq(6'd2, 4'd0, 4'd0, IO, 32'h0, 32'h0, 4'd5);
    cycle();
    idle();
    repeat (3) begin
      cycle();
      check("t25_io_req", io_req_rob_id, 5);
      check("t25_blocked", issue_valid, 0);
    end
    io_ok_rob_id = 4'd5;
    cycle();
    check("t25_valid", issue_valid, 1);
    check("t25_addr", issue_addr, IO);
    idle();

    // Fill across the wrap point with head at 10, then overflow.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_enq(6'd1, 4'd0, 4'd0, 32'(i), 32'h0, 32'h0, 4'd1);
      cycle();
    end
    idle();
    cycle();
    cycle();
    check("t26_empty", count, 0);
    for (int k = 1; k <= 17; k++) begin
      set_enq(6'd1, 4'd0, 4'd0, 32'(k), 32'h0, 32'h0, 4'd1);
      lsu_busy = 1;
      cycle();
      if (k == 12) check("t26_not_full", full, 0);
      if (k == 13) check("t26_full", full, 1);
      if (k == 16) check("t26_no_ovf", overflow_err, 0);
      if (k == 17) begin
        check("t26_ovf", overflow_err, 1);
        check("t26_count", count, 16);
      end
    end
    idle();
    repeat (20) cycle();

    // Flush keeps the committed store prefix.
    do_reset();
    set_enq(6'd8, 4'd0, 4'd0, 32'h1000, 32'h11, 32'h0, 4'd1); lsu_busy = 1; cycle();
    set_enq(6'd9, 4'd0, 4'd0, 32'h2000, 32'h22, 32'h0, 4'd2); lsu_busy = 1; cycle();
    set_enq(6'd3, 4'd0, 4'd0, 32'h3000, 32'h0,  32'h0, 4'd3); lsu_busy = 1; cycle();
    set_enq(6'd8, 4'd0, 4'd0, 32'h4000, 32'h44, 32'h0, 4'd4); lsu_busy = 1; cycle();
    set_enq(6'd4, 4'd0, 4'd0, 32'h5000, 32'h0,  32'h0, 4'd5); lsu_busy = 1; cycle();
    idle(); lsu_busy = 1; commit_valid = 1; commit_rob_id = 4'd1; cycle();
    idle(); lsu_busy = 1; commit_valid = 1; commit_rob_id = 4'd2; cycle();
    idle(); lsu_busy = 1; flush = 1; cycle();
    check("t27_count", count, 2);
    idle();
    cycle();
    check("t27_first", issue_data, 32'h11);
    cycle();
    check("t27_second", issue_data, 32'h22);
    cycle();
    check("t27_drained", count, 0);

    do_reset();
    repeat (3000) begin
      gen_random();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
